// File: rtl/fetch_sequencer.sv
// Instruction fetch control stage: issues reads at the PC, holds the fetched
// word under valid/ready, and pulses the PC counter's increment/load controls.
module fetch_sequencer #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W:0]   pc,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [ADDR_W:0]   pc_load_val,
  output logic              mem_req,
  output logic [ADDR_W:0]   mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W:0]   mem_rdata,
  output logic              instr_valid,
  output logic [DATA_W:0]   instr,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W:0]   redirect_addr,
  input  logic              halt
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, FLUSH} state_t;

  state_t            state_q, state_d;
  logic              pc_inc_q, pc_inc_d;
  logic              pc_load_q, pc_load_d;
  logic [ADDR_W:0]   pc_load_val_q, pc_load_val_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W:0]   mem_addr_q, mem_addr_d;
  logic              instr_valid_q, instr_valid_d;
  logic [DATA_W:0]   instr_q, instr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pc_inc_q      <= 1'b0;
      pc_load_q     <= 1'b0;
      pc_load_val_q <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_inc_q      <= pc_inc_d;
      pc_load_q     <= pc_load_d;
      pc_load_val_q <= pc_load_val_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
    end
  end

  // Redirect outranks everything; an in-flight read without ack must drain in FLUSH.
  always_comb begin
    state_d       = state_q;
    pc_inc_d      = 1'b0;
    pc_load_d     = 1'b0;
    pc_load_val_d = pc_load_val_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;

    if (redirect) begin
      pc_load_d     = 1'b1;
      pc_load_val_d = redirect_addr;
      instr_valid_d = 1'b0;
      case (state_q)
        WAIT, FLUSH: begin
          if (mem_ack) begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
          end else begin
            state_d   = FLUSH;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          // Wait out a pending PC update so the sampled PC is never stale.
          if (!halt && !pc_inc_q && !pc_load_q) begin
            mem_req_d  = 1'b1;
            mem_addr_d = pc;
            state_d    = WAIT;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            mem_req_d     = 1'b0;
            instr_d       = mem_rdata;
            instr_valid_d = 1'b1;
            pc_inc_d      = 1'b1;
            state_d       = HOLD;
          end
        end
        HOLD: begin
          if (instr_valid_q && instr_ready) begin
            instr_valid_d = 1'b0;
            state_d       = IDLE;
          end
        end
        FLUSH: begin
          if (mem_ack) begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign pc_inc      = pc_inc_q;
  assign pc_load     = pc_load_q;
  assign pc_load_val = pc_load_val_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;

endmodule
